vip_stream_out: RTL and testbench

Output stage of the VIP pipeline, directly downstream of `vip_top`. It drains the `vip_top` output FIFO (`fifo_out_data` / `fifo_out_rdreq` / `fifo_out_empty`) and emits a framed video stream with valid/ready flow control and start-of-frame, end-of-line and end-of-frame markers. Frame geometry and frame count come from the same `width` / `height` / `num_frame` bus the image source drives.

---
 rtl/vip_stream_out_if.sv | 48 ++++
 rtl/vip_stream_out.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_vip_stream_out.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_stream_out_if.sv
// -----------------------------------------------------------------------------
// vip_stream_out_if
//
// Framed video stream leaving the VIP output stage. It carries one pixel per
// beat with valid/ready flow control and frame/line markers.
//
// Signals:
//   m_data   pixel (DWIDTH bits), stable while m_valid & !m_ready
//   m_valid  beat present; never depends on m_ready in the same cycle
//   m_ready  sink can take the beat
//   m_sof    first pixel of a frame   (qualified by m_valid)
//   m_eol    last pixel of a line     (qualified by m_valid)
//   m_eof    last pixel of a frame    (qualified by m_valid)
//
// Modports:
//   master  driven by vip_stream_out
//   slave   driven by the downstream consumer
// -----------------------------------------------------------------------------
interface vip_stream_out_if #(
  parameter int DWIDTH = 24
) ();

  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output m_data,
    output m_valid,
    output m_sof,
    output m_eol,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_sof,
    input  m_eol,
    input  m_eof,
    output m_ready
  );

endinterface : vip_stream_out_if

// File: rtl/vip_stream_out.sv
// -----------------------------------------------------------------------------
// vip_stream_out
//
// Output stage of the VIP pipeline. It drains the vip_top output FIFO (read
// data valid one cycle after the pop) and emits a framed valid/ready stream
// with start-of-frame, end-of-line and end-of-frame markers. A run covers
// num_frame frames of width x height pixels; num_frame = 0 streams forever.
//
// Optional feature macro: VIP_STREAM_UNDERRUN_EN
//   When defined, the underrun_cnt port exists and counts ACTIVE cycles in
//   which the sink was ready but no pixel was available (saturating at
//   0xFFFF, cleared at the start of every run).
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       run request (level); ignored once a run is in progress
//   width        pixels per line, latched at start
//   height       lines per frame, latched at start
//   num_frame    frames per run (0 = forever), latched at start
//   fifo_data    FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq   FIFO pop
//   fifo_empty   FIFO empty flag
//   m            output stream (vip_stream_out_if.master)
//   frame_done   one-cycle pulse in the cycle after the m_eof beat is taken
//   busy         high while a run is ACTIVE
//   underrun_cnt stall counter (only with VIP_STREAM_UNDERRUN_EN)
// -----------------------------------------------------------------------------
module vip_stream_out #(
  parameter int DWIDTH = 24,
  parameter int WWIDTH = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [WWIDTH-1:0] width,
  input  logic [WWIDTH-1:0] height,
  input  logic [WWIDTH-1:0] num_frame,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rdreq,
  input  logic              fifo_empty,
  vip_stream_out_if.master  m,
  output logic              frame_done,
  output logic              busy
`ifdef VIP_STREAM_UNDERRUN_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [WWIDTH-1:0] ONE = WWIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Geometry captured at start; input changes during a run are ignored.
  logic [WWIDTH-1:0] width_q, height_q, nframe_q;

  // Request side: position of the next pixel to be popped from the FIFO.
  logic [WWIDTH-1:0] rx_q, ry_q, rf_q;
  logic              req_done_q;   // final pixel of the run already popped

  // Output side: position of the pixel currently at the buffer head.
  logic [WWIDTH-1:0] ox_q, oy_q, of_q;

  // Two-entry skid buffer; entry 0 is the head that drives m_data.
  logic              pend_q;       // a pop issued last cycle, data arrives now
  logic [1:0]        cnt_q;
  logic [DWIDTH-1:0] buf_q [2];

  logic              frame_done_q;

  logic              start;
  logic              active;
  logic              out_valid;
  logic              accept;
  logic              o_last_x, o_last_y, o_last_f, o_eof;
  logic              r_last_x, r_last_y, r_last_f;
  logic [2:0]        occupancy;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign start  = (state_q == ST_IDLE) && enable &&
                  (width != '0) && (height != '0);
  assign active = (state_q == ST_ACTIVE);

  assign out_valid = (cnt_q != 2'd0);
  assign accept    = out_valid && m.m_ready;

  assign o_last_x = (ox_q == width_q - ONE);
  assign o_last_y = (oy_q == height_q - ONE);
  assign o_last_f = (nframe_q != '0) && (of_q == nframe_q - ONE);
  assign o_eof    = o_last_x && o_last_y;

  assign r_last_x = (rx_q == width_q - ONE);
  assign r_last_y = (ry_q == height_q - ONE);
  assign r_last_f = (nframe_q != '0) && (rf_q == nframe_q - ONE);

  // Slots that will be committed after this edge: entries held, plus the
  // read in flight, minus the head leaving this cycle. Discounting the
  // departing head is what allows a pop every cycle while the sink is ready;
  // with the sink stalled the total still caps at two, so the buffer never
  // overflows.
  assign occupancy = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, accept};

  // ---------------------------------------------------------------------------
  // Stream outputs (all derived from registers, never from m_ready)
  // ---------------------------------------------------------------------------
  assign m.m_valid = out_valid;
  assign m.m_data  = buf_q[0];
  assign m.m_sof   = out_valid && (ox_q == '0) && (oy_q == '0);
  assign m.m_eol   = out_valid && o_last_x;
  assign m.m_eof   = out_valid && o_eof;

  assign frame_done = frame_done_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fifo_rdreq = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        busy       = 1'b1;
        fifo_rdreq = !fifo_empty && !req_done_q && (occupancy < 3'd2);
        // Only a finite run ends; num_frame = 0 keeps o_last_f low forever.
        if (accept && o_eof && o_last_f) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Geometry latch and position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      width_q    <= '0;
      height_q   <= '0;
      nframe_q   <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rf_q       <= '0;
      req_done_q <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      of_q       <= '0;
    end else if (start) begin
      width_q    <= width;
      height_q   <= height;
      nframe_q   <= num_frame;
      rx_q       <= '0;
      ry_q       <= '0;
      rf_q       <= '0;
      req_done_q <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      of_q       <= '0;
    end else begin
      // fifo_rdreq is only ever high in ACTIVE.
      if (fifo_rdreq) begin
        if (r_last_x) begin
          rx_q <= '0;
          if (r_last_y) begin
            ry_q <= '0;
            rf_q <= rf_q + ONE;
            if (r_last_f) begin
              req_done_q <= 1'b1;
            end
          end else begin
            ry_q <= ry_q + ONE;
          end
        end else begin
          rx_q <= rx_q + ONE;
        end
      end

      // Output position moves only on an accepted beat, which keeps the
      // markers stable while the sink stalls.
      if (accept) begin
        if (o_last_x) begin
          ox_q <= '0;
          if (o_last_y) begin
            oy_q <= '0;
            of_q <= of_q + ONE;
          end else begin
            oy_q <= oy_q + ONE;
          end
        end else begin
          ox_q <= ox_q + ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-latency buffer
  // ---------------------------------------------------------------------------
  // NOTE: the two buffer words are reset because the head drives m_data,
  // which must read 0 out of reset; a deeper store would not be reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q   <= 1'b0;
      cnt_q    <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      pend_q <= fifo_rdreq;

      unique case ({pend_q, accept})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            buf_q[0] <= fifo_data;
          end else begin
            buf_q[1] <= fifo_data;
          end
          cnt_q <= cnt_q + 2'd1;
        end

        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end

        2'b11: begin
          // Head leaves as new data lands: count stays, contents shift.
          if (cnt_q == 2'd1) begin
            buf_q[0] <= fifo_data;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= fifo_data;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && o_eof;
    end
  end

`ifdef VIP_STREAM_UNDERRUN_EN
  // ---------------------------------------------------------------------------
  // Underrun counter
  // ---------------------------------------------------------------------------
  // Inside ACTIVE the output counters are never exhausted: the final m_eof
  // beat moves the FSM to DONE on the same edge, so ACTIVE alone qualifies.
  logic [15:0] underrun_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_q <= '0;
    end else if (start) begin
      underrun_q <= '0;
    end else if (active && m.m_ready && !out_valid && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule : vip_stream_out

// File: tb/tb_vip_stream_out.sv
// -----------------------------------------------------------------------------
// tb_vip_stream_out
//
// Self-checking bench for vip_stream_out. A queue-like FIFO model feeds the
// DUT; a reference model predicts every accepted beat from the FIFO contents
// and the beat index (x = k mod w, y = (k div w) mod h).
// Inputs change 2 time units after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_vip_stream_out;

  localparam int DWIDTH = 24;
  localparam int WWIDTH = 11;
  localparam int FDEPTH = 1024;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [WWIDTH-1:0] width = '0;
  logic [WWIDTH-1:0] height = '0;
  logic [WWIDTH-1:0] num_frame = '0;
  logic [DWIDTH-1:0] fifo_data = '0;
  logic              fifo_rdreq;
  logic              fifo_empty;
  logic              frame_done;
  logic              busy;
`ifdef VIP_STREAM_UNDERRUN_EN
  logic [15:0]       underrun_cnt;
`endif

  vip_stream_out_if #(.DWIDTH(DWIDTH)) m_if ();

  vip_stream_out #(
    .DWIDTH (DWIDTH),
    .WWIDTH (WWIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .width      (width),
    .height     (height),
    .num_frame  (num_frame),
    .fifo_data  (fifo_data),
    .fifo_rdreq (fifo_rdreq),
    .fifo_empty (fifo_empty),
    .m          (m_if),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef VIP_STREAM_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Upstream FIFO model (registered read data)
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] mem [FDEPTH];
  int                wr_ptr = 0;
  int                rd_ptr = 0;
  logic              fifo_hold = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || fifo_hold;

  always @(posedge clock) begin
    if (fifo_rdreq && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % FDEPTH];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  int   cyc = 0;
  int   start_cyc = 0;
  int   first_beat_cyc = -1;
  int   last_beat_cyc = -1;
  int   beats = 0;
  int   rd_cnt = 0;
  int   out_ptr = 0;
  int   cur_w = 1;
  int   cur_h = 1;
  int   stall_pops = 0;
  int   ready_mode = 0;   // 0 hold, 1 toggle, 2 random
  bit   hold_mode = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_eof_hs = 1'b0;
  bit   fd_seen = 1'b0;
  logic [DWIDTH+2:0] prev_bundle = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle observation at the falling edge.
  task automatic monitor();
    logic [DWIDTH+2:0] bundle;
    int  x;
    int  y;
    bit  e_sof;
    bit  e_eol;
    bit  e_eof;
    cyc++;
    bundle = {m_if.m_data, m_if.m_sof, m_if.m_eol, m_if.m_eof};

    check("frame_done", frame_done, prev_eof_hs);
    if (frame_done) fd_seen = 1'b1;
    prev_eof_hs = 1'b0;

    if (prev_stall) begin
      check("hold_valid", m_if.m_valid, 1);
      check("hold_bundle", bundle, prev_bundle);
    end

    if (fifo_rdreq) begin
      rd_cnt++;
      check("rdreq_when_empty", fifo_empty, 0);
      if (!m_if.m_ready) begin
        stall_pops++;
        check("bp_pops_le2", (stall_pops <= 2) ? 1 : 0, 1);
      end
    end
    if (m_if.m_ready) stall_pops = 0;

    if (m_if.m_valid && m_if.m_ready) begin
      x     = beats % cur_w;
      y     = (beats / cur_w) % cur_h;
      e_eol = (x == cur_w - 1);
      e_sof = (x == 0) && (y == 0);
      e_eof = e_eol && (y == cur_h - 1);
      check("data", m_if.m_data, mem[out_ptr % FDEPTH]);
      check("sof", m_if.m_sof, e_sof);
      check("eol", m_if.m_eol, e_eol);
      check("eof", m_if.m_eof, e_eof);
      out_ptr++;
      beats++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      prev_eof_hs   = e_eof;
    end

    prev_stall  = m_if.m_valid && !m_if.m_ready;
    prev_bundle = bundle;
  endtask

  // One clock: observe at the falling edge, then drive just after the rise.
  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #2;
    case (ready_mode)
      1:       m_if.m_ready = ~m_if.m_ready;
      2:       m_if.m_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    fifo_hold = hold_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % FDEPTH] = DWIDTH'($urandom);
      wr_ptr++;
    end
  endtask

  task automatic start_run(input int w, input int h, input int nf);
    width          = WWIDTH'(w);
    height         = WWIDTH'(h);
    num_frame      = WWIDTH'(nf);
    enable         = 1'b1;
    cur_w          = w;
    cur_h          = h;
    beats          = 0;
    rd_cnt         = 0;
    out_ptr        = rd_ptr;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
    fd_seen        = 1'b0;
    start_cyc      = cyc + 1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && beats < n; i++) tick();
    check({tag, "_beats"}, beats, n);
  endtask

  task automatic wait_done(input int budget, input string tag);
    fd_seen = 1'b0;
    for (int i = 0; i < budget && !fd_seen; i++) tick();
    check({tag, "_frame_done_seen"}, fd_seen, 1);
  endtask

  task automatic finish_run();
    enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frames(input int w, input int h, input int nf, input string tag);
    int total;
    total = w * h * nf;
    start_run(w, h, nf);
    wait_beats(total, total * 10 + 50, tag);
    wait_done(10, tag);
    repeat (3) tick();
    check({tag, "_rd_count"}, rd_cnt, total);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_valid_done"}, m_if.m_valid, 0);
    finish_run();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdreq"}, fifo_rdreq, 0);
    check({tag, "_valid"}, m_if.m_valid, 0);
    check({tag, "_data"}, m_if.m_data, 0);
    check({tag, "_markers"}, {m_if.m_sof, m_if.m_eol, m_if.m_eof}, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef VIP_STREAM_UNDERRUN_EN
    check({tag, "_underrun"}, underrun_cnt, 0);
`endif
  endtask

  task automatic clear_model();
    prev_stall  = 1'b0;
    prev_eof_hs = 1'b0;
    stall_pops  = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    m_if.m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_outputs_zero("reset_state");
    reset = 1'b1;
    tick();

    // Single 4x2 frame, FIFO preloaded, sink always ready.
    push_pixels(8);
    start_run(4, 2, 1);
    tick();
    check("t1_busy_active", busy, 1);
    wait_beats(8, 60, "t1");
    check("t1_first_latency", first_beat_cyc - start_cyc, 3);
    check("t1_burst_len", last_beat_cyc - first_beat_cyc, 7);
    wait_done(5, "t1");
    check("t1_busy_done", busy, 0);
    repeat (4) tick();
    check("t1_rd_count", rd_cnt, 8);
    check("t1_stay_done", busy, 0);
    finish_run();

    // No over-read: 12 pixels available, only 8 may be popped.
    push_pixels(12);
    start_run(4, 2, 1);
    wait_beats(8, 60, "t2");
    wait_done(5, "t2");
    repeat (4) tick();
    check("t2_rd_count", rd_cnt, 8);
    check("t2_fifo_left", wr_ptr - rd_ptr, 4);
    finish_run();

    // Backpressure: sink toggles every cycle; leftover pixels lead the stream.
    push_pixels(12);
    ready_mode = 1;
    run_frames(4, 2, 2, "t3");
    check("t3_fifo_drained", wr_ptr - rd_ptr, 0);
    ready_mode   = 0;
    m_if.m_ready = 1'b1;

    // Randomised geometry, random sink stalls and FIFO gaps.
    for (int it = 0; it < 4; it++) begin
      int w;
      int h;
      int nf;
      w  = int'($urandom_range(1, 5));
      h  = int'($urandom_range(1, 3));
      nf = int'($urandom_range(1, 3));
      push_pixels(w * h * nf);
      ready_mode = 2;
      hold_mode  = 1'b1;
      run_frames(w, h, nf, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_fifo_drained", it), wr_ptr - rd_ptr, 0);
    end
    ready_mode   = 0;
    hold_mode    = 1'b0;
    fifo_hold    = 1'b0;
    m_if.m_ready = 1'b1;
    tick();

    // Continuous 1x1 run: every beat is sof+eol+eof, never reaches DONE.
    push_pixels(6);
    start_run(1, 1, 0);
    wait_beats(6, 40, "t5");
    repeat (5) tick();
    check("t5_busy_forever", busy, 1);
    enable = 1'b0;
    repeat (2) tick();
    check("t5_enable_ignored", busy, 1);
    push_pixels(3);
    wait_beats(9, 40, "t5b");
    reset = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    @(posedge clock);
    #2;
    reset = 1'b1;
    clear_model();
    tick();

    // Reset mid-frame after pixel 3, then a clean restart.
    push_pixels(8);
    start_run(4, 2, 1);
    wait_beats(3, 40, "t6");
    #1;
    reset = 1'b0;
    #1;
    check_outputs_zero("t6_async_reset");
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    clear_model();
    tick();
    push_pixels(8 - (wr_ptr - rd_ptr));
    run_frames(4, 2, 1, "t6_restart");

`ifdef VIP_STREAM_UNDERRUN_EN
    // Underrun: FIFO empty for 5 cycles mid-frame with sink ready.
    begin
      int u0;
      push_pixels(2);
      start_run(4, 2, 1);
      wait_beats(2, 20, "t7");
      tick();
      check("t7_valid_low", m_if.m_valid, 0);
      u0 = int'(underrun_cnt);
      repeat (5) tick();
      check("t7_underrun_delta", int'(underrun_cnt) - u0, 5);
      push_pixels(6);
      wait_beats(8, 60, "t7b");
      wait_done(5, "t7");
      finish_run();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vip_stream_out
